fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Upstream pixel-fetch stage for the VGA output block.
- Reads one frame of RGB888 words linearly from framebuffer memory, starting at a programmable base address.
- Buffers the words in a small FIFO and presents them to the VGA stage on a valid/ready pixel interface.
- The VGA stage pulses frame_start once per frame, ahead of the first active line.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- ADDR_W, 19, framebuffer word-address width.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 2.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse from the VGA stage; starts or restarts a frame fetch.
- fb_base  in  ADDR_W  frame base word address; sampled on frame_start.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  read word address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  24  read data, {R[23:16], G[15:8], B[7:0]}.
- pix_valid  out  1  FIFO head valid.
- pix_ready  in  1  VGA stage consumes a pixel this cycle.
- pix_r, pix_g, pix_b  out  8 each  FIFO head colour; 0 when the FIFO is empty.
- underflow  out  1  sticky; set on pix_ready while the FIFO is empty.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, FIFO is empty, all counters are 0.
- Memory protocol:
  - mem_req and mem_addr are held stable until mem_gnt.
  - Each grant produces exactly one mem_rvalid, in order, at any latency ≥1 cycle.
  - A request and its grant may complete in the same cycle mem_req rises.
- Credit rule: a request may be issued only if outstanding + fifo_count + (1 if a grant occurs this cycle) < FIFO_DEPTH. Consequently the FIFO never overflows; a push into a full FIFO is a design assertion.
- FSM states:
  - IDLE: mem_req=0. On frame_start, latch fb_base into addr, clear req_cnt and the FIFO, go to FETCH.
  - FETCH: mem_req=1 whenever the credit rule allows. Each grant increments addr (ADDR_W wrap-around permitted) and req_cnt. When req_cnt reaches H_ACTIVE*V_ACTIVE with a grant this cycle, go to DRAIN.
  - DRAIN: mem_req=0. Go to IDLE once outstanding == 0 and the FIFO is empty.
- frame_start in FETCH or DRAIN (abort and restart):
  - Flush the FIFO in the same edge.
  - Load discard = outstanding, counting any grant in that cycle.
  - Relatch fb_base, clear req_cnt, go to FETCH.
  - Returns arriving while discard > 0 are dropped and decrement discard. They still count against outstanding for the credit rule.
- FIFO:
  - First-word-fall-through; pix_valid = !empty.
  - Pop on pix_valid && pix_ready.
  - Push on mem_rvalid && discard == 0.
  - Push and pop in the same cycle leave the count unchanged.
  - A push into an empty FIFO shows on pix_* the next cycle (1-cycle rvalid→pix latency).
- Underflow: pix_ready with the FIFO empty drives pix_* = 0 (black) and sets underflow. underflow clears only on reset.
- outstanding: +1 on grant, −1 on rvalid, unchanged when both occur in one cycle. Width is clog2(FIFO_DEPTH)+1.

Decomposition:
- Shared package fb_pkg holds:
  - H_ACTIVE and V_ACTIVE defaults;
  - pixel_t, a packed struct {r, g, b} of 8 bits each;
  - the fsm state_t enum {IDLE, FETCH, DRAIN}.
- One sub-module, fb_fifo: a parameterised synchronous FWFT FIFO with flush, count, full and empty outputs.

Test Plan (bench parameters H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4; memory model returns data = address, latency 2):
- Reset release, no stimulus → mem_req, pix_valid, pix_r/g/b and underflow stay 0 for 20 cycles.
- frame_start with fb_base=0x100, mem_gnt=1, pix_ready=1 → mem_addr sequence 0x100..0x107 (8 grants), pix_b sequence 0x00..0x07, then DRAIN→IDLE and mem_req=0.
- pix_ready=0 throughout → exactly 4 grants (0x100..0x103), then mem_req=0. One pop re-enables mem_req within 1 cycle with mem_addr=0x104.
- Memory latency set to 10, pix_ready=1 immediately after frame_start → underflow=1, pix_r/g/b=0 during the stall, underflow remains 1 after the data arrives.
- frame_start with fb_base=0x200 while 3 reads are outstanding → those 3 returns are dropped, and the first popped pixel equals 0x200.
- RESET_N asserted mid-FETCH, asynchronously between clock edges → mem_req, pix_valid and underflow drop to 0 without waiting for an edge. After release, the FSM stays IDLE until frame_start.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer scan-out fetch path.
package fb_pkg;

   localparam int H_ACTIVE_DFLT = 640;
   localparam int V_ACTIVE_DFLT = 480;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/fb_fifo.sv
// First-word-fall-through pixel FIFO with synchronous flush; head reads as
// black while empty.
module fb_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  pixel_t                   wdata,
   input  logic                     pop,
   output pixel_t                   rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   pixel_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fb_scanout.sv
// Frame fetch engine: streams one frame of RGB888 words from memory into the
// pixel FIFO, with credit-limited requests and restart on frame_start.
//
// state | meaning
// IDLE  | no fetch in progress, mem_req low
// FETCH | issuing reads for the current frame as credit allows
// DRAIN | all reads issued; waiting for returns and the FIFO to empty
module fb_scanout
   import fb_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DFLT,
   parameter int V_ACTIVE   = V_ACTIVE_DFLT,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              frame_start,
   input  logic [ADDR_W-1:0] fb_base,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [23:0]       mem_rdata,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [7:0]        pix_r,
   output logic [7:0]        pix_g,
   output logic [7:0]        pix_b,
   output logic              underflow
);

   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int TOTAL = H_ACTIVE * V_ACTIVE;
   localparam int RCW   = $clog2(TOTAL + 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [RCW-1:0]    req_cnt;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     out_nxt;
   logic [CW-1:0]     discard;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit_sum;
   logic              mem_req_q;
   logic              req_nxt;
   logic              grant;
   logic              last_grant;
   logic              credit_ok;
   logic              fifo_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop_eff;
   pixel_t            head;

   assign grant      = mem_req_q && mem_gnt;
   assign last_grant = grant && (req_cnt == RCW'(TOTAL - 1));
   assign fifo_push  = mem_rvalid && (discard == '0);
   assign pop_eff    = pix_ready && !fifo_empty;

   // Request is registered, so credit is judged on occupancy after this edge.
   assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count}
                     + (CW+1)'(grant) - (CW+1)'(pop_eff);
   assign credit_ok  = credit_sum < (CW+1)'(FIFO_DEPTH);

   always_comb begin
      out_nxt = outstanding;
      if (grant && !mem_rvalid)
         out_nxt = outstanding + 1'b1;
      else if (mem_rvalid && !grant)
         out_nxt = outstanding - 1'b1;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (frame_start) state_nxt = FETCH;
         FETCH:   if (frame_start) state_nxt = FETCH;
                  else if (last_grant) state_nxt = DRAIN;
         DRAIN:   if (frame_start) state_nxt = FETCH;
                  else if (outstanding == '0 && fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A restart drops any pending request so the new address is never
   // presented under a request that was raised for the old one.
   always_comb begin
      req_nxt = 1'b0;
      if (!frame_start && state_nxt == FETCH)
         req_nxt = (mem_req_q && !mem_gnt) || credit_ok;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         addr        <= '0;
         req_cnt     <= '0;
         outstanding <= '0;
         discard     <= '0;
         mem_req_q   <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         outstanding <= out_nxt;
         mem_req_q   <= req_nxt;
         if (pix_ready && fifo_empty) underflow <= 1'b1;
         if (frame_start) begin
            addr    <= fb_base;
            req_cnt <= '0;
            discard <= out_nxt;
         end else begin
            if (grant) begin
               addr    <= addr + 1'b1;
               req_cnt <= req_cnt + 1'b1;
            end
            if (mem_rvalid && discard != '0) discard <= discard - 1'b1;
         end
      end
   end

   fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .flush (frame_start),
      .push  (fifo_push),
      .wdata (pixel_t'(mem_rdata)),
      .pop   (pix_ready),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
      !(fifo_push && fifo_full && !pop_eff && !frame_start));

   assign mem_req   = mem_req_q;
   assign mem_addr  = addr;
   assign pix_valid = !fifo_empty;
   assign pix_r     = head.r;
   assign pix_g     = head.g;
   assign pix_b     = head.b;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout with a small in-order memory model whose
// read data equals the requested address.
module tb_fb_scanout;
   import fb_pkg::*;

   localparam int ADDR_W = 19;

   logic              CLOCK_50 = 1'b0;
   logic              RESET_N = 1'b0;
   logic              frame_start = 1'b0;
   logic [ADDR_W-1:0] fb_base = '0;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid = 1'b0;
   logic [23:0]       mem_rdata = '0;
   logic              pix_valid;
   logic              pix_ready = 1'b0;
   logic [7:0]        pix_r, pix_g, pix_b;
   logic              underflow;

   int n_checks = 0;
   int n_err = 0;
   int lat = 2;
   bit gnt_en = 1'b0;
   int gnt_limit = 1000000;
   int n_grants = 0;
   int cyc = 0;

   logic [ADDR_W-1:0] grant_log[$];
   logic [23:0]       pop_log[$];
   logic [ADDR_W-1:0] pend_d[$];
   int                pend_t[$];

   fb_scanout #(
      .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .frame_start (frame_start),
      .fb_base     (fb_base),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_r       (pix_r),
      .pix_g       (pix_g),
      .pix_b       (pix_b),
      .underflow   (underflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   assign mem_gnt = gnt_en && (n_grants < gnt_limit);

   always @(posedge CLOCK_50) begin
      if (mem_req && mem_gnt) n_grants <= n_grants + 1;
   end

   // Memory model and logging run on the falling edge, mid-cycle.
   always @(negedge CLOCK_50) begin
      cyc <= cyc + 1;
      if (!RESET_N) begin
         pend_d.delete();
         pend_t.delete();
         mem_rvalid <= 1'b0;
         mem_rdata  <= '0;
      end else begin
         if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= {5'd0, pend_d[0]};
            void'(pend_t.pop_front());
            void'(pend_d.pop_front());
         end else begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
         end
         if (mem_req && mem_gnt) begin
            grant_log.push_back(mem_addr);
            pend_d.push_back(mem_addr);
            pend_t.push_back(cyc + lat);
         end
         if (pix_valid && pix_ready) pop_log.push_back({pix_r, pix_g, pix_b});
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_frame(input logic [ADDR_W-1:0] base);
      fb_base     = base;
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      pix_ready = 1'b0;
      RESET_N   = 1'b0;
      tick(2);
      RESET_N   = 1'b1;
      tick(1);
   endtask

   task automatic wait_pops(input int n, input int p0, input int lim, output bit ok);
      int k;
      k  = 0;
      ok = 1'b0;
      while (k < lim && !ok) begin
         if (pop_log.size() - p0 >= n) ok = 1'b1;
         else begin
            tick(1);
            k++;
         end
      end
   endtask

   initial begin
      int  g0, p0;
      bit  ok;
      logic quiet;

      tick(3);
      RESET_N = 1'b1;
      tick(1);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_pix_valid", 32'(pix_valid), 0);
      chk("rst_pix_rgb", {8'd0, pix_r, pix_g, pix_b}, 0);
      chk("rst_underflow", 32'(underflow), 0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      quiet = 1'b0;
      repeat (20) begin
         tick(1);
         quiet = quiet | mem_req | pix_valid | underflow | (|{pix_r, pix_g, pix_b});
      end
      chk("idle_quiet_20cyc", 32'(quiet), 0);

      // Full frame with free-flowing grant and ready.
      g0 = grant_log.size();
      p0 = pop_log.size();
      gnt_en    = 1'b1;
      lat       = 2;
      pix_ready = 1'b1;
      pulse_frame(19'h100);
      wait_pops(8, p0, 300, ok);
      chk("frame_pop_timeout", 32'(ok), 1);
      tick(5);
      chk("frame_grant_cnt", grant_log.size() - g0, 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("frame_addr%0d", i), 32'(grant_log[g0 + i]), 32'h100 + i);
         chk($sformatf("frame_pix%0d", i), 32'(pop_log[p0 + i]), 32'h100 + i);
      end
      chk("frame_done_state", 32'(dut.state), 32'(IDLE));
      chk("frame_done_req", 32'(mem_req), 0);
      chk("frame_done_valid", 32'(pix_valid), 0);

      // Back-pressure: credit limits to FIFO_DEPTH grants.
      do_reset();
      g0 = grant_log.size();
      p0 = pop_log.size();
      pulse_frame(19'h100);
      tick(20);
      chk("bp_grant_cnt", grant_log.size() - g0, 4);
      chk("bp_addr_first", 32'(grant_log[g0]), 32'h100);
      chk("bp_addr_last", 32'(grant_log[g0 + 3]), 32'h103);
      chk("bp_req_off", 32'(mem_req), 0);
      chk("bp_valid", 32'(pix_valid), 1);
      pix_ready = 1'b1;
      tick(1);
      pix_ready = 1'b0;
      chk("bp_pop_val", 32'(pop_log[p0]), 32'h100);
      chk("bp_req_back", 32'(mem_req), 1);
      chk("bp_addr_next", 32'(mem_addr), 32'h104);

      // Long latency with the consumer ready from the start.
      do_reset();
      lat = 10;
      p0  = pop_log.size();
      pulse_frame(19'h100);
      pix_ready = 1'b1;
      tick(3);
      chk("uf_flag", 32'(underflow), 1);
      chk("uf_valid", 32'(pix_valid), 0);
      chk("uf_black", {8'd0, pix_r, pix_g, pix_b}, 0);
      wait_pops(1, p0, 100, ok);
      chk("uf_pop_timeout", 32'(ok), 1);
      chk("uf_first_pix", 32'(pop_log[p0]), 32'h100);
      chk("uf_sticky", 32'(underflow), 1);

      // Restart with three reads in flight.
      do_reset();
      lat       = 10;
      gnt_limit = n_grants + 3;
      g0 = grant_log.size();
      pulse_frame(19'h100);
      tick(6);
      chk("rs_grants_before", grant_log.size() - g0, 3);
      chk("rs_req_held", 32'(mem_req), 1);
      p0 = pop_log.size();
      pulse_frame(19'h200);
      gnt_limit = 1000000;
      pix_ready = 1'b1;
      wait_pops(1, p0, 200, ok);
      chk("rs_pop_timeout", 32'(ok), 1);
      chk("rs_first_pix", 32'(pop_log[p0]), 32'h200);
      chk("rs_first_new_addr", 32'(grant_log[g0 + 3]), 32'h200);

      // Asynchronous reset in the middle of a fetch.
      do_reset();
      lat = 2;
      pix_ready = 1'b1;
      pulse_frame(19'h100);
      tick(5);
      chk("ar_pre_req", 32'(mem_req), 1);
      chk("ar_pre_valid", 32'(pix_valid), 1);
      chk("ar_pre_uf", 32'(underflow), 1);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("ar_req", 32'(mem_req), 0);
      chk("ar_valid", 32'(pix_valid), 0);
      chk("ar_uf", 32'(underflow), 0);
      pix_ready = 1'b0;
      tick(2);
      #2;
      RESET_N = 1'b1;
      g0 = grant_log.size();
      tick(10);
      chk("ar_idle_state", 32'(dut.state), 32'(IDLE));
      chk("ar_idle_req", 32'(mem_req), 0);
      chk("ar_idle_grants", grant_log.size() - g0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
